// File: rtl/spi_byte_sequencer.sv
// Byte-level SPI transaction sequencer: streams a TX buffer to an SPI master under
// a framed chip select and captures the returned bytes into an RX buffer.
module spi_byte_sequencer #(
  parameter int unsigned MAX_BYTES     = 8,
  parameter int unsigned CS_SETUP_CLKS = 2,
  parameter int unsigned CS_HOLD_CLKS  = 2,
  parameter int unsigned CS_GAP_CLKS   = 4
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst,
  input  logic                         i_Wr_En,
  input  logic [$clog2(MAX_BYTES)-1:0] i_Wr_Addr,
  input  logic [7:0]                   i_Wr_Data,
  input  logic [$clog2(MAX_BYTES):0]   i_Len,
  input  logic                         i_Start,
  input  logic [$clog2(MAX_BYTES)-1:0] i_Rd_Addr,
  output logic [7:0]                   o_Rd_Data,
  output logic                         o_Busy,
  output logic                         o_Done,
  output logic                         o_Err,
  output logic [7:0]                   o_TX_Byte,
  output logic                         o_TX_DV,
  input  logic                         i_TX_Ready,
  input  logic                         i_RX_DV,
  input  logic [7:0]                   i_RX_Byte,
  output logic                         o_SPI_CS_n
);

  localparam int unsigned AW = $clog2(MAX_BYTES);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 16;
  // SETUP and HOLD each end one cycle early because SEND and the CS release edge
  // consume the final cycle of their respective windows.
  localparam int unsigned SETUP_LAST = (CS_SETUP_CLKS >= 2) ? CS_SETUP_CLKS - 2 : 0;
  localparam int unsigned HOLD_LAST  = (CS_HOLD_CLKS >= 2) ? CS_HOLD_CLKS - 2 : 0;
  localparam int unsigned GAP_LAST   = (CS_GAP_CLKS >= 1) ? CS_GAP_CLKS - 1 : 0;

  typedef enum logic [2:0] {
    IDLE, SETUP, SEND, WAIT_RX, HOLD, GAP
  } state_e;

  state_e          state_q;
  logic [7:0]      tx_buf_q [MAX_BYTES];
  logic [7:0]      rx_buf_q [MAX_BYTES];
  logic [LW-1:0]   len_q;
  logic [AW-1:0]   idx_q;
  logic [CW-1:0]   cnt_q;
  logic            cs_n_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic            tx_dv_q;
  logic [7:0]      tx_byte_q;

  logic start_ok;
  logic last_byte;

  assign start_ok  = (i_Len != '0) && (i_Len <= LW'(MAX_BYTES));
  assign last_byte = ({1'b0, idx_q} == (len_q - LW'(1)));

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
      for (int unsigned i = 0; i < MAX_BYTES; i++) begin
        tx_buf_q[i] <= '0;
        rx_buf_q[i] <= '0;
      end
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tx_dv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_Wr_En) begin
            tx_buf_q[i_Wr_Addr] <= i_Wr_Data;
          end
          if (i_Start) begin
            if (start_ok) begin
              len_q  <= i_Len;
              idx_q  <= '0;
              cnt_q  <= '0;
              cs_n_q <= 1'b0;
              busy_q <= 1'b1;
              if (CS_SETUP_CLKS >= 2) begin
                state_q <= SETUP;
              end else begin
                state_q <= SEND;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (cnt_q == CW'(SETUP_LAST)) begin
            cnt_q   <= '0;
            state_q <= SEND;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        SEND: begin
          if (i_TX_Ready) begin
            tx_dv_q   <= 1'b1;
            tx_byte_q <= tx_buf_q[idx_q];
            state_q   <= WAIT_RX;
          end
        end
        WAIT_RX: begin
          if (i_RX_DV) begin
            rx_buf_q[idx_q] <= i_RX_Byte;
            cnt_q           <= '0;
            if (!last_byte) begin
              idx_q   <= idx_q + AW'(1);
              state_q <= SEND;
            end else if (CS_HOLD_CLKS >= 2) begin
              state_q <= HOLD;
            end else begin
              cs_n_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= GAP;
            end
          end
        end
        HOLD: begin
          if (cnt_q == CW'(HOLD_LAST)) begin
            cs_n_q  <= 1'b1;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        GAP: begin
          if (cnt_q == CW'(GAP_LAST)) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_Rd_Data  = rx_buf_q[i_Rd_Addr];
  assign o_Busy     = busy_q;
  assign o_Done     = done_q;
  assign o_Err      = err_q;
  assign o_TX_Byte  = tx_byte_q;
  assign o_TX_DV    = tx_dv_q;
  assign o_SPI_CS_n = cs_n_q;

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Bench for spi_byte_sequencer: a behavioural SPI master returns each byte XOR a mask
// after a programmable latency; expectations come from buffer arrays and timing formulas.
`timescale 1ns/1ps
module tb_spi_byte_sequencer;
  localparam int unsigned MB = 8;
  localparam int unsigned S  = 2;
  localparam int unsigned H  = 2;
  localparam int unsigned G  = 4;
  localparam int unsigned AW = 3;
  localparam int unsigned LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [LW-1:0] len;
  logic          start;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy, done, err;
  logic [7:0]    tx_byte;
  logic          tx_dv;
  logic          tx_ready;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          cs_n;

  always #5 clk = ~clk;

  spi_byte_sequencer #(
    .MAX_BYTES(MB), .CS_SETUP_CLKS(S), .CS_HOLD_CLKS(H), .CS_GAP_CLKS(G)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Wr_En(wr_en), .i_Wr_Addr(wr_addr), .i_Wr_Data(wr_data),
    .i_Len(len), .i_Start(start), .i_Rd_Addr(rd_addr), .o_Rd_Data(rd_data),
    .o_Busy(busy), .o_Done(done), .o_Err(err), .o_TX_Byte(tx_byte), .o_TX_DV(tx_dv),
    .i_TX_Ready(tx_ready), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte), .o_SPI_CS_n(cs_n)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int         m_busy, m_cnt, m_lat, stall;
  logic [7:0] m_byte, m_xor;

  logic [7:0] tx_q[$];
  int         tx_cyc[$];
  int         done_cnt, err_cnt, done_cyc, busy_low_cyc;
  bit         cs_ok, cs_at_done;

  logic [7:0] tx_model [MB];
  logic [7:0] rx_model [MB];

  // One clock: advance, then play the SPI master and record DUT strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (stall > 0) stall--;
    rx_dv = 1'b0;
    if (m_busy != 0) begin
      if (m_cnt <= 1) begin
        rx_dv   = 1'b1;
        rx_byte = m_byte ^ m_xor;
        m_busy  = 0;
      end else begin
        m_cnt--;
      end
    end else if (tx_dv) begin
      m_busy = 1;
      m_cnt  = m_lat;
      m_byte = tx_byte;
    end
    tx_ready = (m_busy == 0) && (stall == 0);
    if (tx_dv) begin
      tx_q.push_back(tx_byte);
      tx_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc   = cyc;
      cs_at_done = cs_n;
    end
    if (err) err_cnt++;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    tx_model[a] = d;
  endtask

  // Launch a transaction and run until busy drops after o_Done (bounded).
  task automatic run_txn(input int l, input int inj, input bit same_wr,
                         input logic [7:0] same_data, output int c0);
    int n;
    tx_q.delete(); tx_cyc.delete();
    done_cnt = 0; err_cnt = 0; cs_ok = 1'b1; done_cyc = -1; cs_at_done = 1'b0;
    if (same_wr) begin
      wr_en = 1'b1; wr_addr = '0; wr_data = same_data; tx_model[0] = same_data;
    end
    len = LW'(l); start = 1'b1; c0 = cyc;
    tick();
    start = 1'b0; wr_en = 1'b0;
    n = 0;
    while (!(done_cnt > 0 && busy == 1'b0) && n < 2000) begin
      if (done_cnt == 0 && cs_n !== 1'b0) cs_ok = 1'b0;
      if (n == inj) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 8'h55;
      end
      tick();
      start = 1'b0; wr_en = 1'b0;
      n++;
    end
    busy_low_cyc = cyc;
    if (n >= 2000) begin
      miscompares++;
      $display("FAIL txn_timeout len=%0d: no o_Done/idle within 2000 cycles", l);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vectors++; if (cs_n !== 1'b1) begin miscompares++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
    vectors++; if ({busy, done, err, tx_dv} !== 4'b0) begin miscompares++; $display("FAIL reset_flags got %b want 0000", {busy, done, err, tx_dv}); end
    vectors++; if (tx_byte !== 8'h00) begin miscompares++; $display("FAIL reset_tx_byte got %h want 00", tx_byte); end
    rst = 1'b0;
    tick();
    vectors++; if (busy !== 1'b0 || cs_n !== 1'b1) begin miscompares++; $display("FAIL post_reset_idle busy=%b cs_n=%b want 0/1", busy, cs_n); end
    for (int i = 0; i < int'(MB); i++) begin
      rd_addr = AW'(i);
      tick();
      vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx[%0d] got %h want 00", i, rd_data); end
    end
  endtask

  task automatic test_loopback();
    int c0, exp_done;
    wr(0, 8'hC1); wr(1, 8'hBE); wr(2, 8'hEF);
    m_lat = 3; m_xor = 8'h00;
    run_txn(3, -1, 1'b0, 8'h00, c0);
    exp_done = c0 + 1 + int'(S) + 2 * (m_lat + 2) + m_lat + int'(H);
    vectors++; if (tx_q.size() != 3) begin miscompares++; $display("FAIL loop_tx_count got %0d want 3", tx_q.size()); end
    for (int k = 0; k < tx_q.size(); k++) begin
      vectors++; if (tx_q[k] !== tx_model[k]) begin miscompares++; $display("FAIL loop_tx_byte[%0d] got %h want %h", k, tx_q[k], tx_model[k]); end
    end
    vectors++; if (!cs_ok || cs_at_done !== 1'b1) begin miscompares++; $display("FAIL loop_cs_frame cs_ok=%0d cs_at_done=%b want 1/1", cs_ok, cs_at_done); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL loop_done_count got %0d want 1", done_cnt); end
    vectors++; if (done_cyc != exp_done) begin miscompares++; $display("FAIL loop_done_cycle got %0d want %0d", done_cyc, exp_done); end
    for (int k = 0; k < 3; k++) rx_model[k] = tx_model[k];
    for (int k = 0; k < 3; k++) begin
      rd_addr = AW'(k);
      tick();
      vectors++; if (rd_data !== rx_model[k]) begin miscompares++; $display("FAIL loop_rx[%0d] got %h want %h", k, rd_data, rx_model[k]); end
    end
  endtask

  task automatic test_err();
    for (int t = 0; t < 2; t++) begin
      tx_q.delete(); err_cnt = 0;
      len = (t == 0) ? LW'(0) : LW'(9);
      start = 1'b1;
      tick();
      start = 1'b0;
      vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_pulse len=%0d got %b want 1", len, err); end
      vectors++; if (busy !== 1'b0 || cs_n !== 1'b1) begin miscompares++; $display("FAIL err_state busy=%b cs_n=%b want 0/1", busy, cs_n); end
      tick(); tick(); tick();
      vectors++; if (err_cnt != 1 || tx_q.size() != 0) begin miscompares++; $display("FAIL err_once err_cnt=%0d tx=%0d want 1/0", err_cnt, tx_q.size()); end
    end
  endtask

  task automatic test_busy_ignored();
    int c0;
    logic [7:0] d0;
    d0 = 8'($urandom_range(1, 8'h54));
    wr(0, d0); wr(1, 8'($urandom));
    m_lat = 4; m_xor = 8'h00;
    run_txn(2, 3, 1'b0, 8'h00, c0);
    vectors++; if (done_cnt != 1 || err_cnt != 0) begin miscompares++; $display("FAIL busy_ign_done done=%0d err=%0d want 1/0", done_cnt, err_cnt); end
    vectors++; if (tx_q.size() != 2) begin miscompares++; $display("FAIL busy_ign_tx_count got %0d want 2", tx_q.size()); end
    for (int k = 0; k < 2; k++) rx_model[k] = tx_model[k];
    rd_addr = '0;
    tick();
    vectors++; if (rd_data !== d0) begin miscompares++; $display("FAIL busy_ign_rx0 got %h want %h", rd_data, d0); end
    run_txn(1, -1, 1'b0, 8'h00, c0);
    vectors++; if (tx_q.size() != 1 || tx_q[0] !== d0) begin miscompares++; $display("FAIL busy_ign_txbuf0 got %h want %h", (tx_q.size() > 0) ? tx_q[0] : 8'hxx, d0); end
  endtask

  task automatic test_full();
    int c0;
    for (int k = 0; k < 8; k++) wr(k, 8'(k + 1));
    m_lat = 2; m_xor = 8'h00;
    run_txn(8, -1, 1'b0, 8'h00, c0);
    vectors++; if (tx_q.size() != 8) begin miscompares++; $display("FAIL full_tx_count got %0d want 8", tx_q.size()); end
    for (int k = 0; k < tx_q.size(); k++) begin
      vectors++; if (tx_q[k] !== 8'(k + 1)) begin miscompares++; $display("FAIL full_tx[%0d] got %h want %h", k, tx_q[k], 8'(k + 1)); end
    end
    vectors++; if (busy_low_cyc - done_cyc != int'(G)) begin miscompares++; $display("FAIL full_gap got %0d want %0d", busy_low_cyc - done_cyc, G); end
    for (int k = 0; k < 8; k++) rx_model[k] = 8'(k + 1);
    for (int k = 0; k < 8; k++) begin
      rd_addr = AW'(k);
      tick();
      vectors++; if (rd_data !== rx_model[k]) begin miscompares++; $display("FAIL full_rx[%0d] got %h want %h", k, rd_data, rx_model[k]); end
    end
  endtask

  task automatic test_reset_abort();
    int n, c0;
    for (int k = 0; k < 4; k++) wr(k, 8'($urandom_range(1, 255)));
    m_lat = 3; m_xor = 8'h00;
    tx_q.delete(); done_cnt = 0;
    len = LW'(4); start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (tx_q.size() < 2 && n < 200) begin tick(); n++; end
    vectors++; if (tx_q.size() != 2) begin miscompares++; $display("FAIL abort_reach_tx2 got %0d want 2", tx_q.size()); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (cs_n !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL abort_cs_n cs_n=%b busy=%b want 1/0", cs_n, busy); end
    for (int i = 0; i < 20; i++) tick();
    vectors++; if (done_cnt != 0) begin miscompares++; $display("FAIL abort_no_done got %0d want 0", done_cnt); end
    for (int k = 0; k < int'(MB); k++) begin tx_model[k] = 8'h00; rx_model[k] = 8'h00; end
    for (int k = 0; k < int'(MB); k++) begin
      rd_addr = AW'(k);
      tick();
      vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL abort_rx[%0d] got %h want 00", k, rd_data); end
    end
    m_xor = 8'h00;
    run_txn(8, -1, 1'b0, 8'h00, c0);
    for (int k = 0; k < tx_q.size(); k++) begin
      vectors++; if (tx_q[k] !== 8'h00) begin miscompares++; $display("FAIL abort_tx_buf[%0d] got %h want 00", k, tx_q[k]); end
    end
  endtask

  task automatic test_ready_stall();
    int c0, exp_first;
    wr(0, 8'h3C); wr(1, 8'hA5);
    m_lat = 2; m_xor = 8'h00;
    stall = 20; tx_ready = 1'b0;
    run_txn(2, -1, 1'b0, 8'h00, c0);
    exp_first = c0 + 21;
    vectors++; if (tx_cyc.size() < 1 || tx_cyc[0] != exp_first) begin miscompares++; $display("FAIL stall_first_tx got %0d want %0d", (tx_cyc.size() > 0) ? tx_cyc[0] : -1, exp_first); end
    vectors++; if (!cs_ok) begin miscompares++; $display("FAIL stall_cs_low got break want continuous"); end
    vectors++; if (done_cyc != exp_first + (m_lat + 2) + m_lat + int'(H)) begin miscompares++; $display("FAIL stall_done got %0d want %0d", done_cyc, exp_first + (m_lat + 2) + m_lat + int'(H)); end
    for (int k = 0; k < 2; k++) rx_model[k] = tx_model[k];
  endtask

  task automatic test_random();
    int c0, l, nw, exp_first, exp_done, prev_done;
    bit same;
    logic [7:0] sd;
    prev_done = -1;
    for (int it = 0; it < 12; it++) begin
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) wr($urandom_range(0, MB - 1), 8'($urandom));
      l = $urandom_range(1, MB);
      m_lat = $urandom_range(1, 4);
      m_xor = 8'($urandom);
      same = 1'($urandom);
      sd = 8'($urandom);
      run_txn(l, -1, same, sd, c0);
      if (nw == 0 && prev_done >= 0) begin
        vectors++; if ((c0 + 1) - prev_done != int'(G) + 1) begin miscompares++; $display("FAIL b2b_cs_gap it=%0d got %0d want %0d", it, (c0 + 1) - prev_done, G + 1); end
      end
      exp_first = c0 + 1 + int'(S);
      exp_done = exp_first + (l - 1) * (m_lat + 2) + m_lat + int'(H);
      vectors++; if (tx_q.size() != l) begin miscompares++; $display("FAIL rnd_tx_count it=%0d got %0d want %0d", it, tx_q.size(), l); end
      for (int k = 0; k < tx_q.size(); k++) begin
        vectors++; if (tx_q[k] !== tx_model[k] || tx_cyc[k] != exp_first + k * (m_lat + 2)) begin miscompares++; $display("FAIL rnd_tx[%0d] it=%0d got %h@%0d want %h@%0d", k, it, tx_q[k], tx_cyc[k], tx_model[k], exp_first + k * (m_lat + 2)); end
      end
      vectors++; if (done_cnt != 1 || done_cyc != exp_done || !cs_ok) begin miscompares++; $display("FAIL rnd_done it=%0d got cnt=%0d cyc=%0d cs_ok=%0d want 1/%0d/1", it, done_cnt, done_cyc, cs_ok, exp_done); end
      for (int k = 0; k < l; k++) rx_model[k] = tx_model[k] ^ m_xor;
      prev_done = done_cyc;
      if (it % 3 == 2) begin
        for (int k = 0; k < int'(MB); k++) begin
          rd_addr = AW'(k);
          tick();
          vectors++; if (rd_data !== rx_model[k]) begin miscompares++; $display("FAIL rnd_rx[%0d] it=%0d got %h want %h", k, it, rd_data, rx_model[k]); end
        end
        prev_done = -1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; len = '0; start = 1'b0;
    rd_addr = '0; tx_ready = 1'b1; rx_dv = 1'b0; rx_byte = '0;
    m_busy = 0; m_cnt = 0; m_lat = 1; m_xor = '0; m_byte = '0; stall = 0;
    done_cnt = 0; err_cnt = 0; done_cyc = -1; busy_low_cyc = 0; cs_ok = 1'b1; cs_at_done = 1'b0;
    for (int k = 0; k < int'(MB); k++) begin tx_model[k] = 8'h00; rx_model[k] = 8'h00; end
    test_reset();
    test_loopback();
    test_err();
    test_busy_ignored();
    test_full();
    test_reset_abort();
    test_ready_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
